// File: rtl/pdp_dp_info_pkg.sv
// Shared definitions for the PDP RDMA->DP stream: info field layout and transmit FSM states.
package pdp_dp_info_pkg;

  localparam int INFO_W      = 12;
  localparam int LINE_END    = 4;
  localparam int SURF_END    = 5;
  localparam int FIRST_SPLIT = 6;
  localparam int LAST_SPLIT  = 7;
  localparam int CUBE_END    = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tx_state_e;

endpackage

// File: rtl/nv_nvdla_pdp_rdma_pos_cnt.sv
// Cube position counters (split > channel > height > width) and the info flags of the element
// about to be popped; counters advance by one element per pop.
module nv_nvdla_pdp_rdma_pos_cnt
  import pdp_dp_info_pkg::*;
#(
  parameter int CNT_W   = 13,
  parameter int SPLIT_W = 8,
  parameter int PW_W    = 10
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  input  logic                clr,
  input  logic                adv,
  input  logic [CNT_W-1:0]    cube_width,
  input  logic [CNT_W-1:0]    cube_height,
  input  logic [CNT_W-1:0]    cube_channel,
  input  logic [SPLIT_W-1:0]  split_num,
  input  logic [PW_W-1:0]     pw_first,
  input  logic [PW_W-1:0]     pw_mid,
  input  logic [PW_W-1:0]     pw_last,
  output logic [INFO_W-1:0]   info
);

  logic [CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]   h_cnt;
  logic [CNT_W-1:0]   c_cnt;
  logic [SPLIT_W-1:0] s_cnt;
  logic [CNT_W-1:0]   split_w;
  logic               line_end;
  logic               surf_end;
  logic               cube_end;
  logic               first_split;
  logic               last_split;

  // Without splitting the whole cube width is one split, so it overrides the partial widths.
  always_comb begin
    split_w = cube_width;
    if (split_num != '0) begin
      if (s_cnt == '0)            split_w = CNT_W'(pw_first);
      else if (s_cnt == split_num) split_w = CNT_W'(pw_last);
      else                         split_w = CNT_W'(pw_mid);
    end
  end

  assign line_end    = (w_cnt == split_w);
  assign surf_end    = line_end & (h_cnt == cube_height);
  assign cube_end    = surf_end & (c_cnt == cube_channel);
  assign first_split = (s_cnt == '0);
  assign last_split  = (s_cnt == split_num);

  always_comb begin
    info              = '0;
    info[LINE_END]    = line_end;
    info[SURF_END]    = surf_end;
    info[FIRST_SPLIT] = first_split;
    info[LAST_SPLIT]  = last_split;
    info[CUBE_END]    = cube_end;
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      w_cnt <= '0;
      h_cnt <= '0;
      c_cnt <= '0;
      s_cnt <= '0;
    end else if (clr) begin
      w_cnt <= '0;
      h_cnt <= '0;
      c_cnt <= '0;
      s_cnt <= '0;
    end else if (adv) begin
      w_cnt <= line_end ? '0 : w_cnt + CNT_W'(1);
      if (surf_end)      h_cnt <= '0;
      else if (line_end) h_cnt <= h_cnt + CNT_W'(1);
      if (cube_end)      c_cnt <= '0;
      else if (surf_end) c_cnt <= c_cnt + CNT_W'(1);
      if (cube_end)      s_cnt <= s_cnt + SPLIT_W'(1);
    end
  end

endmodule

// File: rtl/nv_nvdla_pdp_rdma_dp_tx.sv
// PDP RDMA->DP transmit stage: pops read-data FIFO elements, tags each with its cube position
// and presents them through a single output register, one layer per op_en rising edge.
module nv_nvdla_pdp_rdma_dp_tx
  import pdp_dp_info_pkg::*;
#(
  parameter int DW      = 8,
  parameter int CNT_W   = 13,
  parameter int SPLIT_W = 8,
  parameter int PW_W    = 10
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 reg2dp_op_en,
  input  logic [CNT_W-1:0]     reg2dp_cube_in_width,
  input  logic [CNT_W-1:0]     reg2dp_cube_in_height,
  input  logic [CNT_W-1:0]     reg2dp_cube_in_channel,
  input  logic [SPLIT_W-1:0]   reg2dp_split_num,
  input  logic [PW_W-1:0]      reg2dp_partial_width_in_first,
  input  logic [PW_W-1:0]      reg2dp_partial_width_in_mid,
  input  logic [PW_W-1:0]      reg2dp_partial_width_in_last,
  input  logic                 dat_fifo_pvld,
  output logic                 dat_fifo_prdy,
  input  logic [DW-1:0]        dat_fifo_pd,
  output logic                 pdp_rdma2dp_valid,
  input  logic                 pdp_rdma2dp_ready,
  output logic [DW+INFO_W-1:0] pdp_rdma2dp_pd,
  output logic                 rdma_eg_done,
  output tx_state_e            dbg_state
);

  // Handshake: a transfer happens on a clock edge where valid & ready are both high; once valid
  // rises, valid and pd hold unchanged until that transfer. Same rule on the FIFO side (pvld/prdy).

  tx_state_e           state;
  tx_state_e           state_nxt;
  logic                op_en_d1;
  logic                layer_start;
  logic                in_run;
  logic                last_popped;
  logic                pop;
  logic                accept_last;
  logic [INFO_W-1:0]   info;
  logic [CNT_W-1:0]    cfg_width;
  logic [CNT_W-1:0]    cfg_height;
  logic [CNT_W-1:0]    cfg_channel;
  logic [SPLIT_W-1:0]  cfg_split_num;
  logic [PW_W-1:0]     cfg_pw_first;
  logic [PW_W-1:0]     cfg_pw_mid;
  logic [PW_W-1:0]     cfg_pw_last;

  assign layer_start   = (state == IDLE) & reg2dp_op_en & ~op_en_d1;
  assign dat_fifo_prdy = in_run & ~last_popped & (~pdp_rdma2dp_valid | pdp_rdma2dp_ready);
  assign pop           = dat_fifo_prdy & dat_fifo_pvld;
  assign accept_last   = pdp_rdma2dp_valid & pdp_rdma2dp_ready &
                         pdp_rdma2dp_pd[DW+CUBE_END] & pdp_rdma2dp_pd[DW+LAST_SPLIT];
  assign dbg_state     = state;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state <= IDLE;
    else                  state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (layer_start) state_nxt = RUN;
      RUN:     if (accept_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_run       = 1'b0;
    rdma_eg_done = 1'b0;
    unique case (state)
      RUN:     in_run = 1'b1;
      DONE:    rdma_eg_done = 1'b1;
      default: ;
    endcase
  end

  // Layer registers are captured once at start so mid-layer register writes cannot skew the walk.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      op_en_d1      <= 1'b0;
      cfg_width     <= '0;
      cfg_height    <= '0;
      cfg_channel   <= '0;
      cfg_split_num <= '0;
      cfg_pw_first  <= '0;
      cfg_pw_mid    <= '0;
      cfg_pw_last   <= '0;
    end else begin
      op_en_d1 <= reg2dp_op_en;
      if (layer_start) begin
        cfg_width     <= reg2dp_cube_in_width;
        cfg_height    <= reg2dp_cube_in_height;
        cfg_channel   <= reg2dp_cube_in_channel;
        cfg_split_num <= reg2dp_split_num;
        cfg_pw_first  <= reg2dp_partial_width_in_first;
        cfg_pw_mid    <= reg2dp_partial_width_in_mid;
        cfg_pw_last   <= reg2dp_partial_width_in_last;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      pdp_rdma2dp_valid <= 1'b0;
      pdp_rdma2dp_pd    <= '0;
      last_popped       <= 1'b0;
    end else begin
      if (layer_start)
        last_popped <= 1'b0;
      else if (pop && info[CUBE_END] && info[LAST_SPLIT])
        last_popped <= 1'b1;
      if (pop) begin
        pdp_rdma2dp_valid <= 1'b1;
        pdp_rdma2dp_pd    <= {info, dat_fifo_pd};
      end else if (pdp_rdma2dp_ready) begin
        pdp_rdma2dp_valid <= 1'b0;
      end
    end
  end

  nv_nvdla_pdp_rdma_pos_cnt #(
    .CNT_W   (CNT_W),
    .SPLIT_W (SPLIT_W),
    .PW_W    (PW_W)
  ) u_pos_cnt (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .clr             (layer_start),
    .adv             (pop),
    .cube_width      (cfg_width),
    .cube_height     (cfg_height),
    .cube_channel    (cfg_channel),
    .split_num       (cfg_split_num),
    .pw_first        (cfg_pw_first),
    .pw_mid          (cfg_pw_mid),
    .pw_last         (cfg_pw_last),
    .info            (info)
  );

endmodule
